// File: rtl/boxcar_pkg.sv
// Shared constants for the boxcar filter chain: default sample width,
// FIFO level width helper and drop-counter width.
package boxcar_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DROP_CNT_W     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  // A level counter must hold 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LEVEL_W_DEF = level_width(FIFO_DEPTH_DEF);

endpackage

// File: rtl/boxcar_decimator_if.sv
// Sample input, valid/ready output and status signals of boxcar_decimator.
// o_drop_count exists only when BOXCAR_DECIMATOR_DROP_CNT_EN is defined.
interface boxcar_decimator_if #(
  parameter int DATA_WIDTH = boxcar_pkg::DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = boxcar_pkg::FIFO_DEPTH_DEF
);
  import boxcar_pkg::*;

  logic [DATA_WIDTH-1:0]              i_data;
  logic                               i_valid;
  logic                               i_phase_clr;
  logic [DATA_WIDTH-1:0]              o_data;
  logic                               o_valid;
  logic                               i_ready;
  logic                               o_overflow;
  logic [level_width(FIFO_DEPTH)-1:0] o_level;
`ifdef BOXCAR_DECIMATOR_DROP_CNT_EN
  logic [DROP_CNT_W-1:0]              o_drop_count;

  modport master (
    output i_data, i_valid, i_phase_clr, i_ready,
    input  o_data, o_valid, o_overflow, o_level, o_drop_count
  );

  modport slave (
    input  i_data, i_valid, i_phase_clr, i_ready,
    output o_data, o_valid, o_overflow, o_level, o_drop_count
  );
`else
  modport master (
    output i_data, i_valid, i_phase_clr, i_ready,
    input  o_data, o_valid, o_overflow, o_level
  );

  modport slave (
    input  i_data, i_valid, i_phase_clr, i_ready,
    output o_data, o_valid, o_overflow, o_level
  );
`endif

endinterface

// File: rtl/boxcar_decimator_sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry sits in a dedicated output
// register, so rd_data/empty are flops with no path from push/wr_data.
module sync_fifo
  import boxcar_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int LEVEL_W = level_width(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]   rd_data,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LEVEL_W-1:0] count_q;
  logic [LEVEL_W-1:0] count_d;
  logic [WIDTH-1:0]   head_q;
  logic [WIDTH-1:0]   head_d;
  logic               valid_q;

  // head_q mirrors mem[rd_ptr_q]; on a pop it must already hold the successor,
  // which is the incoming word when the FIFO would otherwise run empty.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LEVEL_W'(1);
      2'b01:   count_d = count_q - LEVEL_W'(1);
      default: count_d = count_q;
    endcase
    if (pop) begin
      if (count_q > LEVEL_W'(1)) begin
        head_d = mem[rd_ptr_q + PTR_W'(1)];
      end else if (push) begin
        head_d = wr_data;
      end
    end else if (push && (count_q == '0)) begin
      head_d = wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= (count_d != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = head_q;
  assign level   = count_q;
  assign full    = (count_q == LEVEL_W'(DEPTH));
  assign empty   = !valid_q;

endmodule

// File: rtl/boxcar_decimator.sv
// Keeps one in every DECIM boxcar samples and queues them for a valid/ready
// consumer. BOXCAR_DECIMATOR_DROP_CNT_EN adds a saturating drop counter.
module boxcar_decimator
  import boxcar_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic              i_clk,
  input logic              i_reset,
  boxcar_decimator_if.slave bus
);

  localparam int LEVEL_W = level_width(FIFO_DEPTH);
  localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

  logic [PHASE_W-1:0]    phase_q;
  logic [PHASE_W-1:0]    phase_d;
  logic [PHASE_W-1:0]    phase_eff;
  logic                  keep;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [LEVEL_W-1:0]    fifo_level;
  logic                  overflow_q;

  // A phase clear acts on the current sample, not the next one.
  always_comb begin
    phase_eff = bus.i_phase_clr ? '0 : phase_q;
    keep      = bus.i_valid && (phase_eff == '0);
    phase_d   = phase_q;
    if (bus.i_valid) begin
      phase_d = (phase_eff == PHASE_LAST) ? '0 : phase_eff + PHASE_W'(1);
    end else if (bus.i_phase_clr) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) phase_q <= '0;
    else         phase_q <= phase_d;
  end

  assign pop  = !fifo_empty && bus.i_ready;
  assign push = keep && (!fifo_full || pop);
  assign drop = keep && !push;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.i_data),
    .rd_data (fifo_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  assign bus.o_data     = fifo_data;
  assign bus.o_valid    = !fifo_empty;
  assign bus.o_level    = fifo_level;
  assign bus.o_overflow = overflow_q;

`ifdef BOXCAR_DECIMATOR_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign bus.o_drop_count = drop_cnt_q;
`endif

endmodule

// File: doc/boxcar_decimator.md
# boxcar_decimator

- Downstream stage of the boxcar (moving-average) filter.
- Consumes the filter's 8-bit smoothed output stream and keeps one sample in every `DECIM`.
- Buffers kept samples in a small FIFO and presents them on a valid/ready output handshake to the next consumer.
- Drops samples when the FIFO is full and flags the loss.

## Interface
- `DATA_WIDTH`, 8: sample width; matches the boxcar filter output.
- `DECIM`, 4: decimation ratio, ≥1. At 1, every valid input sample is kept.
- `FIFO_DEPTH`, 4: total buffered samples, including the output register. Power of two, ≥2.
- `i_clk`  in  1: single clock.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_data`  in  DATA_WIDTH: filtered sample from the boxcar filter.
- `i_valid`  in  1: sample strobe. Tie to 1 when the filter runs every clock.
- `i_phase_clr`  in  1: resynchronises the decimation phase.
- `o_data`  out  DATA_WIDTH: head-of-queue sample.
- `o_valid`  out  1: `o_data` holds a valid sample.
- `i_ready`  in  1: consumer accepts `o_data` this cycle.
- `o_overflow`  out  1: sticky; set by any dropped kept-sample.
- `o_level`  out  $clog2(FIFO_DEPTH)+1: number of buffered samples.
- `o_drop_count`  out  8: present only with `BOXCAR_DECIMATOR_DROP_CNT_EN`.

## Operation
- **Phase counter** counts 0..DECIM-1 and advances on each `i_valid`.
  - Wraps from DECIM-1 to 0.
  - A sample is *kept* when `i_valid` is high and the phase is 0.
  - The first valid sample after reset is always kept.
- **`i_phase_clr`:** the phase is treated as 0 in the same cycle. If `i_valid` is also high, that sample is kept and the phase becomes 1 (or stays 0 when DECIM=1). If `i_valid` is low, the phase becomes 0.
- **Push:** a kept sample is written when `o_level < FIFO_DEPTH`, or when a pop occurs in the same cycle.
- **Drop:** otherwise the kept sample is discarded, `o_overflow` is set, and the phase still advances.
- **Pop:** occurs when `o_valid && i_ready`. The next entry moves to the output register.
- **Order:** samples leave strictly in arrival order, with no reordering or duplication.
- **`o_level` update:** +1 on push only, −1 on pop only, unchanged on push+pop. Saturates at neither bound; overflow and underflow are impossible by construction.
- **Clearing `o_overflow`:** cleared only by `i_reset`.
- **Data path:** no arithmetic on sample values. Data is bit-exact from input to output.
- **Reset (asynchronous, any time, including mid-transfer):**
  - `o_data`=0, `o_valid`=0, `o_overflow`=0, `o_level`=0, drop count=0, phase=0.
  - All buffered samples are discarded.

## Timing
- **Latency:** 1 cycle. A sample kept at edge k into an empty FIFO has `o_valid`=1 with that `o_data` after edge k.
- **Output registers:** `o_data` and `o_valid` are registered outputs with no combinational path from `i_data`/`i_valid`.
- **`i_ready` path:** `i_ready` affects only the next-cycle state. There is no combinational path to `o_valid`.
- **Stall:** while `o_valid && !i_ready`, `o_data` is held stable.
- **Throughput:** one output per cycle with `i_ready` held high. Back-to-back pops need no bubble.
- **Simultaneous pop and empty-after-pop:** `o_valid` drops after the edge unless a push occurs in the same cycle. With a push, the pushed sample appears on the next cycle with no bubble.
- **Full FIFO, kept sample and pop in the same cycle:** the sample is accepted and `o_level` stays at FIFO_DEPTH.

## Configuration
- Macro: `BOXCAR_DECIMATOR_DROP_CNT_EN`.
- **Defined:** `o_drop_count` port exists.
  - 8-bit counter of dropped kept-samples, +1 per drop.
  - Saturates at 255 and resets to 0.
- **Undefined:** port and counter are absent. `o_overflow` is the only loss indication.

## Structure
- Package `boxcar_pkg` holds:
  - the default `DATA_WIDTH` (8), shared with the boxcar filter;
  - the level-width helper constant;
  - the drop-counter width (8).
- One sub-module, `sync_fifo`:
  - parameterised by width and depth;
  - show-ahead, registered output;
  - push/pop/level/full/empty.
- `boxcar_decimator` contains the phase counter, keep/drop logic, overflow flag and drop counter.

## Test plan
- **Reset and startup:** hold `i_reset`=1, then release. `i_valid`=1 with `i_data` = 0x10, 0x11, ..., `i_ready`=1, DECIM=4. Expect:
  - all outputs 0 during reset;
  - output sequence 0x10, 0x14, 0x18;
  - each sample appears 1 cycle after its input edge.
- **DECIM=1 passthrough:** ramp 0x00..0xFF with `i_ready`=1. Expect every value out, 1-cycle latency, `o_level` ≤1.
- **Backpressure and overflow:** DECIM=1, FIFO_DEPTH=4, `i_ready`=0, push 0xA0..0xA5. Expect:
  - `o_level`=4;
  - `o_overflow`=1 after 0xA4;
  - with the macro defined, `o_drop_count`=2;
  - after raising `i_ready`, output sequence 0xA0..0xA3, and `o_data` stable at 0xA0 throughout the stall.
- **Full with simultaneous pop:** fill to 4 entries, then pulse `i_ready`=1 for one cycle together with push 0xB7. Expect no drop, `o_level` stays 4, and 0xB7 is last out.
- **Phase clear:** DECIM=4 with inputs 0x20..0x2F. Pulse `i_phase_clr` with 0x22. Expect outputs 0x20, 0x22, 0x26, 0x2A.
- **Reset mid-operation:** assert `i_reset` asynchronously, away from a clock edge, with 3 entries buffered. Expect `o_valid`=0, `o_level`=0 and `o_overflow`=0 immediately. After release, the first valid input is kept.
